// File: rtl/queue_wr_arbiter.sv
// queue_wr_arbiter
//   Shares the single write port of one ram_queue among NUM_REQ producers.
//   Arbitration is round-robin. When MAX_BURST > 1, the producer that wins a
//   beat keeps the grant for up to MAX_BURST beats. Queue-full backpressure is
//   honoured. The arbiter also keeps an occupancy count from the write and
//   read handshakes, because the queue itself only exports full and empty.
//
//   Ports
//     clk, reset_n   clock; synchronous active-low reset
//     req_valid_i    per-producer valid
//     req_data_i     per-producer data, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready_o    one-hot accept (transfer = valid & ready)
//     q_wvalid_o     to queue wvalid_i
//     q_wdata_o      to queue wdata_i
//     q_full_i       from queue full_o
//     q_empty_i      from queue empty_o
//     q_rready_i     copy of the consumer's queue rready_i
//     grant_o        one-hot current grant, 0 when nothing is requesting
//     count_o        entries held in the queue, saturating in [0, 2**LOG2_SIZE]
module queue_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int LOG2_SIZE  = 2,
    parameter int MAX_BURST  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          q_wvalid_o,
    output logic [DATA_WIDTH-1:0]         q_wdata_o,
    input  logic                          q_full_i,
    input  logic                          q_empty_i,
    input  logic                          q_rready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [LOG2_SIZE:0]            count_o
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [LOG2_SIZE:0] CNT_MAX = (LOG2_SIZE + 1)'(2 ** LOG2_SIZE);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   owner, owner_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [BCNT_W-1:0]  beat_cnt, beat_cnt_n;
    logic [LOG2_SIZE:0] count_n;

    logic               locked;
    logic [PTR_W-1:0]   base, cand, rr_idx, gnt_idx, gnt_next;
    logic               rr_hit, gnt_any, wr, rd;

    // The lock only holds while the owner keeps asserting valid. Once the
    // owner drops, the same cycle is arbitrated normally, so no bubble is
    // inserted. rr_ptr already points past the owner (set at burst entry).
    // While reset is asserted, arbitration behaves as if rr_ptr were 0 and
    // no burst were in progress.
    assign locked = reset_n && (state == BURST) && req_valid_i[owner];
    assign base   = reset_n ? rr_ptr : '0;

    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(base) + i) % NUM_REQ);
            if (!rr_hit && req_valid_i[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign gnt_any  = locked | rr_hit;
    assign gnt_idx  = locked ? owner : rr_idx;
    assign gnt_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Output process
    always_comb begin
        grant_o     = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
        q_wvalid_o  = |(grant_o & req_valid_i) & ~q_full_i;
        req_ready_o = grant_o & {NUM_REQ{~q_full_i}};
        q_wdata_o   = gnt_any ? req_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign wr = q_wvalid_o;
    assign rd = q_rready_i & ~q_empty_i;

    // Next-state process. A full stall produces no wr, so nothing advances.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        beat_cnt_n = beat_cnt;
        rr_ptr_n   = rr_ptr;
        if (locked) begin
            if (wr) begin
                beat_cnt_n = beat_cnt + 1'b1;
                if (beat_cnt_n == BCNT_W'(MAX_BURST))
                    state_n = IDLE;
            end
        end else begin
            state_n = IDLE;
            if (wr) begin
                rr_ptr_n = gnt_next;
                if (MAX_BURST > 1) begin
                    state_n    = BURST;
                    owner_n    = gnt_idx;
                    beat_cnt_n = BCNT_W'(1);
                end
            end
        end

        count_n = count_o;
        if (wr && !rd && count_o != CNT_MAX)
            count_n = count_o + 1'b1;
        else if (rd && !wr && count_o != '0)
            count_n = count_o - 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            count_o  <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
            count_o  <= count_n;
        end
    end

endmodule

// File: tb/tb_queue_wr_arbiter.sv
module tb_queue_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic        q_full, q_empty, q_rready;

    logic [3:0] ready_o [2];
    logic       wvalid_o [2];
    logic [3:0] wdata_o [2];
    logic [3:0] grant_o [2];
    logic [2:0] count_o [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance 0 bursts up to two beats, instance 1 is plain round-robin.
    queue_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .LOG2_SIZE(2), .MAX_BURST(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(ready_o[0]), .q_wvalid_o(wvalid_o[0]), .q_wdata_o(wdata_o[0]),
        .q_full_i(q_full), .q_empty_i(q_empty), .q_rready_i(q_rready),
        .grant_o(grant_o[0]), .count_o(count_o[0]));

    queue_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .LOG2_SIZE(2), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(ready_o[1]), .q_wvalid_o(wvalid_o[1]), .q_wdata_o(wdata_o[1]),
        .q_full_i(q_full), .q_empty_i(q_empty), .q_rready_i(q_rready),
        .grant_o(grant_o[1]), .count_o(count_o[1]));

    // Reference model: who holds a burst lock (-1 = nobody), how many beats
    // it has used, where round-robin search starts, and queue occupancy.
    int mb     [2] = '{2, 1};
    int m_lock [2];
    int m_beats[2];
    int m_ptr  [2];
    int m_cnt  [2];

    logic [3:0] e_grant[2], e_ready[2], e_wdata[2];
    logic       e_wv[2];

    function automatic int pick(int k);
        int start;
        if (reset_n && m_lock[k] >= 0 && req_valid[m_lock[k]]) return m_lock[k];
        start = reset_n ? m_ptr[k] : 0;
        for (int i = 0; i < 4; i++)
            if (req_valid[(start + i) % 4]) return (start + i) % 4;
        return -1;
    endfunction

    task automatic model_eval();
        int g;
        for (int k = 0; k < 2; k++) begin
            g = pick(k);
            e_grant[k] = (g < 0) ? 4'b0 : 4'(1 << g);
            e_wv[k]    = (g >= 0) && !q_full;
            e_wdata[k] = (g < 0) ? 4'h0 : req_data[g*4 +: 4];
            e_ready[k] = q_full ? 4'b0 : e_grant[k];
        end
    endtask

    task automatic tick();
        int g;
        bit wr, rd;
        rd = q_rready && !q_empty;
        for (int k = 0; k < 2; k++) begin
            g  = pick(k);
            wr = (g >= 0) && !q_full;
            if (!reset_n) begin
                m_lock[k] = -1; m_beats[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
            end else begin
                if (wr && !rd && m_cnt[k] < 4) m_cnt[k]++;
                else if (rd && !wr && m_cnt[k] > 0) m_cnt[k]--;
                if (m_lock[k] >= 0 && req_valid[m_lock[k]]) begin
                    if (wr) begin
                        m_beats[k]++;
                        if (m_beats[k] == mb[k]) m_lock[k] = -1;
                    end
                end else begin
                    m_lock[k] = -1;
                    if (wr) begin
                        m_ptr[k] = (g + 1) % 4;
                        if (mb[k] > 1) begin m_lock[k] = g; m_beats[k] = 1; end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic f, input logic rr, input logic e);
        req_valid = v; q_full = f; q_rready = rr; q_empty = e;
        model_eval();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_data = 16'hDCBA;
        drive(4'b0110, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'b0110, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (grant_o[k] !== 4'b0010 || count_o[k] !== 3'd0) begin
                bad++;
                $display("FAIL reset_state[%0d]: grant=%b count=%0d want grant=0010 count=0", k, grant_o[k], count_o[k]);
            end
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0, 1'b0, 1'b0);
            total++;
            if (grant_o[1] !== 4'(1 << (i % 4)) || count_o[1] !== 3'(i)) begin
                bad++;
                $display("FAIL rr_mb1 cyc%0d: grant=%b count=%0d want grant=%b count=%0d",
                         i, grant_o[1], count_o[1], 4'(1 << (i % 4)), i);
            end
            tick();
        end
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        total++;
        if (count_o[1] !== 3'd4) begin
            bad++;
            $display("FAIL rr_mb1_sat: count=%0d want 4", count_o[1]);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_data = 16'h0A00;
        drive(4'b0100, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (grant_o[k] !== 4'b0100 || wvalid_o[k] !== 1'b1 || wdata_o[k] !== 4'hA || ready_o[k] !== 4'b0100) begin
                bad++;
                $display("FAIL single_req2[%0d]: grant=%b wv=%b wdata=%h ready=%b want 0100 1 a 0100",
                         k, grant_o[k], wvalid_o[k], wdata_o[k], ready_o[k]);
            end
        end
        tick();
    endtask

    task automatic test_burst();
        logic [3:0] seq [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
        do_reset();
        req_data = 16'h4321;
        for (int i = 0; i < 6; i++) begin
            drive(4'b0011, 1'b0, 1'b1, 1'b0);
            total++;
            if (grant_o[0] !== seq[i] || wdata_o[0] !== e_wdata[0]) begin
                bad++;
                $display("FAIL burst_seq cyc%0d: grant=%b wdata=%h want %b %h", i, grant_o[0], wdata_o[0], seq[i], e_wdata[0]);
            end
            tick();
        end
        // owner 0 drops after one beat
        do_reset();
        drive(4'b0011, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'b0010, 1'b0, 1'b0, 1'b1);
        total++;
        if (grant_o[0] !== 4'b0010 || wvalid_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL burst_drop: grant=%b wv=%b want 0010 1", grant_o[0], wvalid_o[0]);
        end
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1010, 1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (grant_o[k] !== 4'b0010 || ready_o[k] !== 4'b0000 || wvalid_o[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL full_stall[%0d] cyc%0d: grant=%b ready=%b wv=%b want 0010 0000 0",
                             k, i, grant_o[k], ready_o[k], wvalid_o[k]);
                end
            end
            tick();
        end
        drive(4'b1010, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ready_o[k] !== 4'b0010 || wvalid_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL full_release[%0d]: ready=%b wv=%b want 0010 1", k, ready_o[k], wvalid_o[k]);
            end
        end
        tick();
    endtask

    task automatic test_count();
        do_reset();
        drive(4'b0001, 1'b0, 1'b0, 1'b1); tick();
        drive(4'b0001, 1'b0, 1'b0, 1'b0); tick();
        drive(4'b0001, 1'b0, 1'b1, 1'b0);          // write and read together
        total++;
        if (count_o[0] !== 3'd2) begin
            bad++; $display("FAIL count_two: count=%0d want 2", count_o[0]);
        end
        tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        total++;
        if (count_o[0] !== 3'd2) begin
            bad++; $display("FAIL count_wr_rd: count=%0d want 2", count_o[0]);
        end
        tick(); tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);          // read-only at zero
        total++;
        if (count_o[0] !== 3'd0) begin
            bad++; $display("FAIL count_drain: count=%0d want 0", count_o[0]);
        end
        tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (count_o[0] !== 3'd0) begin
            bad++; $display("FAIL count_floor: count=%0d want 0", count_o[0]);
        end
        tick();
        // fill: queue reports full once three entries are held
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, (m_cnt[0] >= 3), 1'b0, (m_cnt[0] == 0));
            tick();
        end
        drive(4'b1111, (m_cnt[0] >= 3), 1'b0, 1'b0);
        total++;
        if (count_o[0] !== 3'd3 || wvalid_o[0] !== 1'b0 || ready_o[0] !== 4'b0000) begin
            bad++;
            $display("FAIL count_fill: count=%0d wv=%b ready=%b want 3 0 0000", count_o[0], wvalid_o[0], ready_o[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(4'b1000, 1'b0, 1'b0, 1'b1); tick();
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        total++;
        if (grant_o[0] !== 4'b1000) begin
            bad++; $display("FAIL burst_owner3: grant=%b want 1000", grant_o[0]);
        end
        reset_n = 1'b0;
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        total++;
        if (grant_o[0] !== 4'b0001) begin
            bad++; $display("FAIL reset_in_burst: grant=%b want 0001", grant_o[0]);
        end
        tick();
        reset_n = 1'b1;
        drive(4'b1111, 1'b0, 1'b0, 1'b1);
        total++;
        if (grant_o[0] !== 4'b0001 || count_o[0] !== 3'd0) begin
            bad++;
            $display("FAIL after_reset_burst: grant=%b count=%0d want 0001 0", grant_o[0], count_o[0]);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset_n  = ($urandom_range(0, 99) != 0);
            req_data = 16'($urandom);
            drive(4'($urandom), (m_cnt[0] == 4) || ($urandom_range(0, 5) == 0),
                  1'($urandom), (m_cnt[0] == 0));
            for (int k = 0; k < 2; k++) begin
                total++;
                if (grant_o[k] !== e_grant[k] || ready_o[k] !== e_ready[k] || wvalid_o[k] !== e_wv[k] ||
                    wdata_o[k] !== e_wdata[k] || count_o[k] !== 3'(m_cnt[k])) begin
                    bad++;
                    $display("FAIL random[%0d] cyc%0d: grant=%b ready=%b wv=%b wdata=%h count=%0d want %b %b %b %h %0d",
                             k, i, grant_o[k], ready_o[k], wvalid_o[k], wdata_o[k], count_o[k],
                             e_grant[k], e_ready[k], e_wv[k], e_wdata[k], m_cnt[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = -1; m_beats[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        end
        reset_n = 1'b0; req_valid = '0; req_data = '0;
        q_full = 1'b0; q_empty = 1'b1; q_rready = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_burst();
        test_full_stall();
        test_count();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
